// File: rtl/t_pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// t_pulse_gen_pkg
//  Shared definitions for the pushbutton-to-T-pulse front end and the T stage
//  it feeds: the 2-bit FSM state encoding, the pulse counter width and a
//  couple of constant helpers used to size internal counters.
//  No ports (package).
// ---------------------------------------------------------------------------
package t_pulse_gen_pkg;

   localparam int PULSE_CNT_W = 8;

   // Debounce FSM states. IDLE/DB_PRESS report "not pressed",
   // HELD/DB_RELEASE report "pressed".
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_HELD       = 2'd2,
      ST_DB_RELEASE = 2'd3
   } state_e;

   // Ceiling log2, usable in constant expressions. clog2(1) = 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end
      if (c > m) begin
         m = c;
      end
      return m;
   endfunction

endpackage

// File: rtl/t_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// t_pulse_gen_if
//  Groups the button-side inputs and the pulse-side outputs of t_pulse_gen.
//  Signals:
//   btn_in     raw asynchronous pushbutton, active-high
//   en         pulse enable (gates t_out and pulse_cnt only)
//   t_out      single-cycle toggle pulse to the T stage
//   pressed    debounced button level
//   pulse_cnt  number of emitted pulses, wraps
//  Modports: master = whoever drives the button and consumes pulses,
//            slave  = the pulse generator itself.
// ---------------------------------------------------------------------------
interface t_pulse_gen_if;
   import t_pulse_gen_pkg::*;

   logic                   btn_in;
   logic                   en;
   logic                   t_out;
   logic                   pressed;
   logic [PULSE_CNT_W-1:0] pulse_cnt;

   modport master (
      output btn_in,
      output en,
      input  t_out,
      input  pressed,
      input  pulse_cnt
   );

   modport slave (
      input  btn_in,
      input  en,
      output t_out,
      output pressed,
      output pulse_cnt
   );

endinterface

// File: rtl/t_pulse_gen_btn_sync.sv
// ---------------------------------------------------------------------------
// t_pulse_gen_btn_sync
//  Plain flop chain that brings the asynchronous button into the clk domain.
//  Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset, clears the chain to 0
//   d      in  asynchronous input
//   q      out synchronised copy of d, SYNC_STAGES clocks late
// ---------------------------------------------------------------------------
module t_pulse_gen_btn_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift the raw input in at the bottom of the chain each clock.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   // Chain register; cleared so a held button after reset looks like a fresh rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/t_pulse_gen.sv
// ---------------------------------------------------------------------------
// t_pulse_gen
//  Turns a raw bouncing pushbutton into clean single-cycle T pulses:
//  synchronise, debounce both edges, emit one pulse per accepted press and,
//  optionally, auto-repeat pulses while the button stays held.
//  Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of t_pulse_gen_if (btn_in, en -> t_out, pressed, pulse_cnt)
// ---------------------------------------------------------------------------
module t_pulse_gen
   import t_pulse_gen_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 200
) (
   input  logic         clk,
   input  logic         rst_n,
   t_pulse_gen_if.slave bus
);

   localparam int CNT_W = clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
   // After a repeat pulse the counter restarts REPEAT_PERIOD steps below the
   // fire value. If the period exceeds the delay this is a "negative" value
   // that wraps through zero, which still takes exactly REPEAT_PERIOD steps.
   localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
   localparam bit               RPT_ON     = (REPEAT_DELAY != 0);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "t_pulse_gen: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $fatal(1, "t_pulse_gen: DEBOUNCE_CYCLES must be >= 1");
   end
   if (REPEAT_DELAY < 0) begin : g_bad_delay
      $fatal(1, "t_pulse_gen: REPEAT_DELAY must be >= 0");
   end
   if (REPEAT_PERIOD < 1) begin : g_bad_period
      $fatal(1, "t_pulse_gen: REPEAT_PERIOD must be >= 1");
   end

   logic btn_s;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
   logic [CNT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
   logic [CNT_W-1:0]       rpt_inc;
   logic                   fire;
   logic                   t_out_q, t_out_d;
   logic                   pressed_q, pressed_d;
   logic [PULSE_CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

   t_pulse_gen_btn_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_btn_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.btn_in),
      .q     (btn_s)
   );

   // Debounce FSM and counters. A press needs DEBOUNCE_CYCLES+1 consecutive
   // high samples (one in IDLE, the rest in DB_PRESS) and a release the same
   // number of low samples. The repeat counter only runs while HELD sees the
   // button high, so it freezes across a release bounce.
   always_comb begin
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      rpt_cnt_d = rpt_cnt_q;
      rpt_inc   = rpt_cnt_q + CNT_W'(1);
      fire      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (btn_s) begin
               state_d  = ST_DB_PRESS;
               db_cnt_d = '0;
            end
         end

         ST_DB_PRESS: begin
            if (!btn_s) begin
               state_d = ST_IDLE;
            end else if (db_cnt_q == DB_LAST) begin
               state_d   = ST_HELD;
               rpt_cnt_d = '0;
               fire      = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + CNT_W'(1);
            end
         end

         ST_HELD: begin
            if (!btn_s) begin
               state_d  = ST_DB_RELEASE;
               db_cnt_d = '0;
            end else if (RPT_ON) begin
               // Firing on the incremented value puts the first repeat pulse
               // exactly REPEAT_DELAY clocks after the press pulse.
               if (rpt_inc == RPT_FIRST) begin
                  fire      = 1'b1;
                  rpt_cnt_d = RPT_RELOAD;
               end else begin
                  rpt_cnt_d = rpt_inc;
               end
            end
         end

         ST_DB_RELEASE: begin
            if (btn_s) begin
               state_d = ST_HELD;
            end else if (db_cnt_q == DB_LAST) begin
               state_d = ST_IDLE;
            end else begin
               db_cnt_d = db_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pressed_d   = (state_d == ST_HELD) || (state_d == ST_DB_RELEASE);
      // A pulse fired while disabled is simply lost.
      t_out_d     = fire & bus.en;
      pulse_cnt_d = pulse_cnt_q + PULSE_CNT_W'(t_out_d);
   end

   // State, counters and registered outputs all clear together on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         db_cnt_q    <= '0;
         rpt_cnt_q   <= '0;
         t_out_q     <= 1'b0;
         pressed_q   <= 1'b0;
         pulse_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         t_out_q     <= t_out_d;
         pressed_q   <= pressed_d;
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

   assign bus.t_out     = t_out_q;
   assign bus.pressed   = pressed_q;
   assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_t_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_t_pulse_gen
//  Drives two pulse generators from the same button: dut_a with repeat off,
//  dut_b with REPEAT_DELAY=10 / REPEAT_PERIOD=5, both with 2 sync stages and
//  a debounce of 4. Directed scenarios check exact pulse timing; a random
//  phase compares both against a run-length reference model.
// ---------------------------------------------------------------------------
module tb_t_pulse_gen;
   import t_pulse_gen_pkg::*;

   localparam int DB   = 4;
   localparam int RD_B = 10;
   localparam int RP_B = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic btn_in = 1'b0;
   logic en     = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   t_pulse_gen_if bus_a ();
   t_pulse_gen_if bus_b ();

   assign bus_a.btn_in = btn_in;
   assign bus_a.en     = en;
   assign bus_b.btn_in = btn_in;
   assign bus_b.en     = en;

   t_pulse_gen #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (0),
      .REPEAT_PERIOD   (200)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   t_pulse_gen #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD_B),
      .REPEAT_PERIOD   (RP_B)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   // Reference model: a delay line for synchronisation, then "the accepted
   // level flips after DB+1 consecutive samples of the other level". A press
   // flip fires a pulse; while held, repeats fire on the REPEAT_DELAY-th held
   // high sample and every REPEAT_PERIOD samples after that.
   typedef struct packed {
      logic [1:0] chain;
      logic       level;
      int         run;
      int         ticks;
      logic       t_exp;
      logic [7:0] cnt;
   } model_t;

   function automatic model_t model_step(input model_t m, input logic btn,
                                         input logic en_i, input int rd, input int rp);
      model_t n = m;
      logic   s;
      logic   fire;
      logic   held;
      s       = m.chain[1];
      n.chain = {m.chain[0], btn};
      fire    = 1'b0;
      held    = m.level && (m.run == 0);
      if (s != m.level) begin
         n.run = m.run + 1;
         if (n.run == DB + 1) begin
            n.level = ~m.level;
            n.run   = 0;
            if (n.level) begin
               fire    = 1'b1;
               n.ticks = 0;
            end
         end
      end else begin
         n.run = 0;
         if (held && rd != 0) begin
            n.ticks = m.ticks + 1;
            if (n.ticks >= rd && ((n.ticks - rd) % rp) == 0) begin
               fire = 1'b1;
            end
         end
      end
      n.t_exp = fire & en_i;
      n.cnt   = m.cnt + {7'd0, n.t_exp};
      return n;
   endfunction

   model_t ma, mb;

   // Models advance on the same edges as the DUTs and reset with them.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= '0;
         mb <= '0;
      end else begin
         ma <= model_step(ma, btn_in, en, 0, 1);
         mb <= model_step(mb, btn_in, en, RD_B, RP_B);
      end
   end

   // T-stage stand-in fed by dut_a's pulses.
   logic t_state;
   int   t_toggles;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_state   <= 1'b0;
         t_toggles <= 0;
      end else if (bus_a.t_out) begin
         t_state   <= ~t_state;
         t_toggles <= t_toggles + 1;
      end
   end

   // Hold the button at one level for n cycles (inputs change on negedges).
   task automatic applyStimulus(input logic b, input int n);
      btn_in = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      btn_in = 1'b0;
      en     = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus_a.t_out, bus_a.pressed, bus_a.pulse_cnt} !== 10'd0) begin
         errors++;
         $display("[TB] FAIL reset_a: got t_out=%b pressed=%b cnt=%0d expected all 0",
                  bus_a.t_out, bus_a.pressed, bus_a.pulse_cnt);
      end
      checks++;
      if ({bus_b.t_out, bus_b.pressed, bus_b.pulse_cnt} !== 10'd0) begin
         errors++;
         $display("[TB] FAIL reset_b: got t_out=%b pressed=%b cnt=%0d expected all 0",
                  bus_b.t_out, bus_b.pressed, bus_b.pulse_cnt);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_a.t_out, bus_a.pressed, bus_a.pulse_cnt} !== 10'd0) begin
         errors++;
         $display("[TB] FAIL post_reset_a: got t_out=%b pressed=%b cnt=%0d expected all 0",
                  bus_a.t_out, bus_a.pressed, bus_a.pulse_cnt);
      end
   endtask

   task automatic test_clean_press();
      logic [7:0] c0;
      logic       exp_t;
      c0     = bus_a.pulse_cnt;
      btn_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         exp_t = (i == 7);
         checks++;
         if (bus_a.t_out !== exp_t) begin
            errors++;
            $display("[TB] FAIL clean_t_out cycle %0d: got %b expected %b", i, bus_a.t_out, exp_t);
         end
         checks++;
         if (bus_a.pressed !== (i >= 7)) begin
            errors++;
            $display("[TB] FAIL clean_pressed cycle %0d: got %b expected %b", i, bus_a.pressed, (i >= 7));
         end
      end
      checks++;
      if (bus_a.pulse_cnt !== c0 + 8'd1) begin
         errors++;
         $display("[TB] FAIL clean_cnt: got %0d expected %0d", bus_a.pulse_cnt, c0 + 8'd1);
      end
      applyStimulus(1'b0, 10);
      checks++;
      if (bus_a.pressed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clean_release_pressed: got %b expected 0", bus_a.pressed);
      end
   endtask

   task automatic test_bounce();
      logic       pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic       rel [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] c0;
      logic       exp_t;
      c0 = bus_a.pulse_cnt;
      // Stable high starts at pattern index 6, so the pulse lands 7 clocks later.
      for (int k = 0; k < 25; k++) begin
         btn_in = (k < 8) ? pat[k] : 1'b1;
         @(negedge clk);
         exp_t = ((k + 1) == 13);
         checks++;
         if (bus_a.t_out !== exp_t) begin
            errors++;
            $display("[TB] FAIL bounce_press cycle %0d: got %b expected %b", k + 1, bus_a.t_out, exp_t);
         end
      end
      for (int k = 0; k < 18; k++) begin
         btn_in = (k < 6) ? rel[k] : 1'b0;
         @(negedge clk);
         checks++;
         if (bus_a.t_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bounce_release cycle %0d: got %b expected 0", k + 1, bus_a.t_out);
         end
      end
      checks++;
      if (bus_a.pressed !== 1'b0 || bus_a.pulse_cnt !== c0 + 8'd1) begin
         errors++;
         $display("[TB] FAIL bounce_end: got pressed=%b cnt=%0d expected pressed=0 cnt=%0d",
                  bus_a.pressed, bus_a.pulse_cnt, c0 + 8'd1);
      end
   endtask

   task automatic test_repeat();
      logic [7:0] c0;
      logic       exp_b;
      c0     = bus_b.pulse_cnt;
      btn_in = 1'b1;
      for (int i = 1; i <= 39; i++) begin
         @(negedge clk);
         exp_b = (i inside {7, 17, 22, 27, 32, 37});
         checks++;
         if (bus_b.t_out !== exp_b) begin
            errors++;
            $display("[TB] FAIL repeat_t_out cycle %0d: got %b expected %b", i, bus_b.t_out, exp_b);
         end
         checks++;
         if (bus_a.t_out !== (i == 7)) begin
            errors++;
            $display("[TB] FAIL norepeat_t_out cycle %0d: got %b expected %b", i, bus_a.t_out, (i == 7));
         end
      end
      applyStimulus(1'b0, 12);
      checks++;
      if (bus_b.pulse_cnt !== c0 + 8'd6) begin
         errors++;
         $display("[TB] FAIL repeat_cnt: got %0d expected %0d", bus_b.pulse_cnt, c0 + 8'd6);
      end
   endtask

   task automatic test_enable();
      logic [7:0] c0;
      c0     = bus_a.pulse_cnt;
      en     = 1'b0;
      btn_in = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         checks++;
         if (bus_a.t_out !== 1'b0 || bus_b.t_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enable_t_out cycle %0d: got a=%b b=%b expected 0", i, bus_a.t_out, bus_b.t_out);
         end
      end
      checks++;
      if (bus_a.pressed !== 1'b1 || bus_a.pulse_cnt !== c0) begin
         errors++;
         $display("[TB] FAIL enable_state: got pressed=%b cnt=%0d expected pressed=1 cnt=%0d",
                  bus_a.pressed, bus_a.pulse_cnt, c0);
      end
      applyStimulus(1'b0, 10);
      en = 1'b1;
   endtask

   task automatic test_reset_mid_held();
      applyStimulus(1'b1, 12);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus_a.t_out, bus_a.pressed, bus_a.pulse_cnt} !== 10'd0 || bus_b.pressed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got t_out=%b pressed=%b cnt=%0d pressed_b=%b expected all 0",
                  bus_a.t_out, bus_a.pressed, bus_a.pulse_cnt, bus_b.pressed);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         checks++;
         if (bus_a.t_out !== (i == 7) || bus_a.pressed !== (i >= 7)) begin
            errors++;
            $display("[TB] FAIL reset_repress cycle %0d: got t_out=%b pressed=%b expected t_out=%b pressed=%b",
                     i, bus_a.t_out, bus_a.pressed, (i == 7), (i >= 7));
         end
      end
      applyStimulus(1'b0, 10);
      checks++;
      if (bus_a.pulse_cnt !== 8'd1) begin
         errors++;
         $display("[TB] FAIL reset_repress_cnt: got %0d expected 1", bus_a.pulse_cnt);
      end
   endtask

   task automatic test_wrap();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      for (int p = 0; p < 256; p++) begin
         applyStimulus(1'b1, 9);
         applyStimulus(1'b0, 8);
      end
      checks++;
      if (bus_a.pulse_cnt !== 8'd0 || bus_b.pulse_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL wrap_cnt: got a=%0d b=%0d expected 0", bus_a.pulse_cnt, bus_b.pulse_cnt);
      end
      checks++;
      if (t_toggles !== 256 || t_state !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_tstage: got toggles=%0d state=%b expected 256 and 0", t_toggles, t_state);
      end
   endtask

   task automatic test_random();
      int len;
      for (int b = 0; b < 80; b++) begin
         btn_in = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) begin
            en = $urandom_range(0, 1);
         end
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            checks++;
            if (bus_a.t_out !== ma.t_exp || bus_a.pressed !== ma.level || bus_a.pulse_cnt !== ma.cnt) begin
               errors++;
               $display("[TB] FAIL random_a: got t_out=%b pressed=%b cnt=%0d expected t_out=%b pressed=%b cnt=%0d",
                        bus_a.t_out, bus_a.pressed, bus_a.pulse_cnt, ma.t_exp, ma.level, ma.cnt);
            end
            checks++;
            if (bus_b.t_out !== mb.t_exp || bus_b.pressed !== mb.level || bus_b.pulse_cnt !== mb.cnt) begin
               errors++;
               $display("[TB] FAIL random_b: got t_out=%b pressed=%b cnt=%0d expected t_out=%b pressed=%b cnt=%0d",
                        bus_b.t_out, bus_b.pressed, bus_b.pulse_cnt, mb.t_exp, mb.level, mb.cnt);
            end
         end
      end
      en = 1'b1;
      applyStimulus(1'b0, 12);
   endtask

   // Scenario sequence; each task leaves the button released at a negedge.
   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_repeat();
      test_enable();
      test_reset_mid_held();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
